// File: rtl/aes_inv_key_sched.sv
// Purpose: AES-128 reverse key schedule; walks round keys 10 down to 0 from the round-10 key.
// Latency: first key (idx 10) valid one cycle after start; one key per handshake, no bubbles.
// Backpressure: rk_out/rk_idx held while rk_valid && !rk_ready; next key derived only on accept.
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_last,
  input  logic         eq_inv,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [127:0] cur_key;
  logic         eq_lat;
  logic [127:0] next_key;
  logic [127:0] mixed_key;
  logic         mid_round;

  function automatic logic [7:0] s_box(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; 9/b/d/e products built from an xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int j = 0; j < 4; j++) begin
      a[j]  = c[(3-j)*8 +: 8];
      x2    = xt(a[j]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[j] = x8 ^ a[j];
      mb[j] = x8 ^ x2 ^ a[j];
      md[j] = x8 ^ x4 ^ a[j];
      me[j] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // One step backwards through the schedule: round i key -> round i-1 key.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, rot, sub;
    w3  = k[31:0] ^ k[63:32];
    w2  = k[63:32] ^ k[95:64];
    w1  = k[95:64] ^ k[127:96];
    rot = {w3[23:0], w3[31:24]};
    sub = {s_box(rot[31:24]), s_box(rot[23:16]), s_box(rot[15:8]), s_box(rot[7:0])};
    w0  = k[127:96] ^ sub ^ {rcon(i), 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Combinational derivation of the next (older) key and the mixed form of the current one.
  always_comb begin
    next_key  = inv_step(cur_key, rk_idx);
    mixed_key = {inv_mix_col(cur_key[127:96]), inv_mix_col(cur_key[95:64]),
                 inv_mix_col(cur_key[63:32]), inv_mix_col(cur_key[31:0])};
    mid_round = (rk_idx >= 4'd1) && (rk_idx <= 4'(NR - 1));
  end

  // Outer keys (first and last) are always emitted untransformed.
  assign rk_out = (eq_lat && mid_round) ? mixed_key : cur_key;

  // Control FSM: IDLE accepts start, EMIT walks keys on handshakes, DONE pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_key  <= '0;
      eq_lat   <= 1'b0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cur_key  <= key_last;
            rk_idx   <= 4'(NR);
            eq_lat   <= eq_inv;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_idx != 4'd0) begin
              cur_key <= next_key;
              rk_idx  <= rk_idx - 4'd1;
            end else begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- AES-128 inverse (reverse-order) key schedule; the decryption-side counterpart of the forward key expander.
- Accepts the round-10 key and regenerates round keys 10 down to 0 on the fly, one per handshake; no 11-entry key buffer.
- Optional equivalent-inverse-cipher mode applies InvMixColumns to round keys 9..1.
- Feeds the decryption datapath; round-0 output equals the original cipher key.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new schedule; sampled only in IDLE.
- key_last  in  128  round-10 key; word w0 = [127:96] … w3 = [31:0]; sampled with start.
- eq_inv  in  1  1 = InvMixColumns applied to keys 9..1; sampled with start.
- rk_ready  in  1  consumer accepts rk_out this cycle.
- rk_valid  out  1  rk_out / rk_idx hold a valid round key.
- rk_out  out  128  current round key, same word order as key_last.
- rk_idx  out  4  round number of rk_out, 10 down to 0.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after round key 0 is accepted.

Behaviour:
- Reset values: rk_valid=0, rk_out=0, rk_idx=0, busy=0, done=0, state=IDLE. Internal cur_key=0, eq_lat=0.
- State IDLE:
  - start=1 → cur_key<=key_last, rk_idx<=10, eq_lat<=eq_inv, state<=EMIT.
  - start=0 → remain in IDLE.
  - Latency: start accepted at cycle N → rk_valid=1 with rk_idx=10 at cycle N+1.
- State EMIT:
  - rk_valid=1, busy=1.
  - rk_out = (eq_lat && 1<=rk_idx<=9) ? InvMixColumns(cur_key) : cur_key. Keys 10 and 0 are never transformed.
  - rk_out and rk_idx are stable while rk_valid && !rk_ready.
  - Handshake on rk_valid && rk_ready:
    - If rk_idx>0: cur_key <= inv_step(cur_key, rk_idx) and rk_idx <= rk_idx-1 in the same cycle; remain in EMIT.
    - If rk_idx==0: state<=DONE.
  - rk_ready held high → 11 consecutive keys in 11 cycles, no bubbles.
- inv_step(k, i), with w0..w3 taken from k:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon[i], 24'h0}
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - RotWord: bytes [a,b,c,d] → [b,c,d,a].
  - SubWord uses 4 instances of the combinational forward s_box.
- InvMixColumns: combinational, per 32-bit column, GF(2^8) constants 0e,0b,0d,09, polynomial 0x11b. The clocked inverse-mix-columns block is not reused (it would add a cycle).
- State DONE (one cycle): done=1, rk_valid=0, busy=0; next state IDLE. start is ignored in DONE.
- Boundary conditions:
  - start while busy or in DONE: ignored; no restart, key_last not resampled.
  - eq_inv / key_last changing mid-schedule: no effect (latched copies used).
  - rst mid-operation: next cycle all outputs at reset values; state IDLE; any partial schedule discarded.
  - rk_ready high while rk_valid=0: no effect.
  - rst and start in the same cycle: rst wins.
  - rk_idx never wraps below 0.
- Only in-range rcon indices (1..10) are reachable; any out-of-range index selects 00.

Test Plan:
- FIPS-197 A.1, eq_inv=0, rk_ready=1, key_last=d014f9a8c9ee2589e13f0cc8b6630ca6 → then:
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - idx9 = ac7766f319fadc2128d12941575c006e
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done at cycle N+12.
- Same key, eq_inv=1 → idx10 and idx0 unchanged; idx9 equals InvMixColumns(ac7766f3…006e) from the bench reference model; idx1..9 all transformed.
- Back-pressure: toggle rk_ready pseudo-randomly → identical 11-key sequence; rk_out/rk_idx stable during every stall; done exactly once.
- start pulsed at idx 5 with a different key_last → ignored; sequence continues with the original key; busy stays high.
- rst asserted at idx 4 → next cycle rk_valid=0, busy=0, rk_out=0. A new start then yields idx10 = new key_last after one cycle.
- rst and start in the same cycle → stays IDLE. Back-to-back: start asserted in the cycle after the done pulse → new schedule accepted, rk_valid at the following cycle.
